// File: rtl/tail_light_seq_if.sv
// tail_light_seq_if: driver requests into the controller and lamp drives out of it.
// BRAKE exists only when TAILLIGHT_BRAKE_EN is defined.
interface tail_light_seq_if #(
    parameter int N_LAMPS = 3
);
    logic LEFT;
    logic RIGHT;
    logic HAZ;
`ifdef TAILLIGHT_BRAKE_EN
    logic BRAKE;
`endif
    logic [N_LAMPS-1:0] left_lamps;
    logic [N_LAMPS-1:0] right_lamps;
    logic [1:0] mode;
    logic step_tick;
`ifdef TAILLIGHT_BRAKE_EN
    modport master (output LEFT, RIGHT, HAZ, BRAKE, input left_lamps, right_lamps, mode, step_tick);
    modport slave (input LEFT, RIGHT, HAZ, BRAKE, output left_lamps, right_lamps, mode, step_tick);
`else
    modport master (output LEFT, RIGHT, HAZ, input left_lamps, right_lamps, mode, step_tick);
    modport slave (input LEFT, RIGHT, HAZ, output left_lamps, right_lamps, mode, step_tick);
`endif
endinterface

// File: rtl/tail_light_seq.sv
// tail_light_seq: sequential tail-light sweep / hazard controller with step prescaler.
// Optional brake overlay enabled by defining TAILLIGHT_BRAKE_EN.
module tail_light_seq #(
    parameter int N_LAMPS  = 3,
    parameter int STEP_DIV = 1
) (
    input logic Clk,
    input logic reset_n,
    tail_light_seq_if.slave bus
);
    localparam int DW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int SW = $clog2(N_LAMPS + 1);
    typedef enum logic [1:0] {IDLE = 2'd0, SWEEP_L = 2'd1, SWEEP_R = 2'd2, FLASH = 2'd3} state_t;
    state_t state, state_nx, req;
    logic [DW-1:0] div_cnt;
    logic [SW-1:0] step, step_nx;
    logic tick;
    logic step_tick_q;
    logic [N_LAMPS-1:0] sweep, left_nx, right_nx, left_q, right_q;
    assign tick = div_cnt == DW'(STEP_DIV - 1);
    always_comb begin
        req = (bus.HAZ || (bus.LEFT && bus.RIGHT)) ? FLASH :
              bus.LEFT ? SWEEP_L : bus.RIGHT ? SWEEP_R : IDLE;
        state_nx = tick ? req : state;
        step_nx = step;
        if (tick)
            step_nx = (req != state || state == IDLE) ? '0 :
                      (state == FLASH) ? SW'(step == '0) :
                      (step == SW'(N_LAMPS)) ? '0 : step + SW'(1);
        sweep = '0;
        for (int i = 0; i < N_LAMPS; i++)
            sweep[i] = i < int'(step_nx);
        left_nx = (state_nx == FLASH) ? {N_LAMPS{step_nx == '0}} :
                  (state_nx == SWEEP_L) ? sweep : '0;
        right_nx = (state_nx == FLASH) ? {N_LAMPS{step_nx == '0}} :
                   (state_nx == SWEEP_R) ? sweep : '0;
`ifdef TAILLIGHT_BRAKE_EN
        // brake lights every side not currently sweeping; hazard flash wins
        if (bus.BRAKE && state_nx != FLASH) begin
            if (state_nx != SWEEP_L) left_nx = '1;
            if (state_nx != SWEEP_R) right_nx = '1;
        end
`endif
    end
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            step <= '0;
            div_cnt <= '0;
            left_q <= '0;
            right_q <= '0;
            step_tick_q <= 1'b0;
        end else begin
            state <= state_nx;
            step <= step_nx;
            div_cnt <= tick ? '0 : div_cnt + DW'(1);
            left_q <= left_nx;
            right_q <= right_nx;
            step_tick_q <= tick;
        end
    end
    assign bus.left_lamps = left_q;
    assign bus.right_lamps = right_q;
    assign bus.mode = state;
    assign bus.step_tick = step_tick_q;
endmodule

// File: tb/tb_tail_light_seq.sv
// tb_tail_light_seq: scoreboard bench; dut_a is N=3 stepping every clock, dut_b is N=5 stepping every 4 clocks.
module tb_tail_light_seq;
    logic Clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    logic ia_brake = 1'b0;
    int total = 0;
    int bad = 0;
    always #5 Clk = ~Clk;

    tail_light_seq_if #(.N_LAMPS(3)) ia ();
    tail_light_seq_if #(.N_LAMPS(5)) ib ();
`ifdef TAILLIGHT_BRAKE_EN
    assign ia.BRAKE = ia_brake;
    assign ib.BRAKE = 1'b0;
`endif
    tail_light_seq #(.N_LAMPS(3), .STEP_DIV(1)) dut_a (.Clk(Clk), .reset_n(rst_a), .bus(ia));
    tail_light_seq #(.N_LAMPS(5), .STEP_DIV(4)) dut_b (.Clk(Clk), .reset_n(rst_b), .bus(ib));

    typedef struct {
        logic [4:0] l;
        logic [4:0] r;
        logic [1:0] m;
        string tag;
    } exp_t;
    exp_t qa[$];
    exp_t qb[$];

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got mode/left/right=%b want %b", name, act, req);
        end
    endtask

    function automatic logic [11:0] pk_a();
        return {ia.mode, 5'(ia.left_lamps), 5'(ia.right_lamps)};
    endfunction

    function automatic logic [11:0] pk_b();
        return {ib.mode, ib.left_lamps, ib.right_lamps};
    endfunction

    always @(posedge Clk) begin
        exp_t e;
        #2;
        if (rst_a && ia.step_tick && qa.size() > 0) begin
            e = qa.pop_front();
            check(e.tag, pk_a(), {e.m, e.l, e.r});
        end
    end

    int since = 0;
    logic [11:0] prev_b = '0;
    always @(posedge Clk) begin
        exp_t e;
        logic [11:0] cur;
        #2;
        cur = pk_b();
        if (!rst_b) since = 0;
        else begin
            since++;
            if (ib.step_tick) begin
                check("b_tick_period", 12'(since), 12'd4);
                since = 0;
                if (qb.size() > 0) begin
                    e = qb.pop_front();
                    check(e.tag, cur, {e.m, e.l, e.r});
                end
            end else check("b_hold_between_ticks", cur, prev_b);
        end
        prev_b = cur;
    end

    task automatic drive_a(input logic l, input logic r, input logic h, input logic b,
                           input logic [4:0] el, input logic [4:0] er, input logic [1:0] em,
                           input string tag);
        @(negedge Clk);
        ia.LEFT = l;
        ia.RIGHT = r;
        ia.HAZ = h;
        ia_brake = b;
        qa.push_back('{el, er, em, tag});
    endtask

    task automatic drive_b(input logic l, input logic r, input logic h,
                           input logic [4:0] el, input logic [4:0] er, input logic [1:0] em,
                           input string tag);
        ib.LEFT = l;
        ib.RIGHT = r;
        ib.HAZ = h;
        qb.push_back('{el, er, em, tag});
        repeat (4) @(negedge Clk);
    endtask

    task automatic seq_a();
        ia.LEFT = 1'b0;
        ia.RIGHT = 1'b0;
        ia.HAZ = 1'b0;
        repeat (2) @(negedge Clk);
        check("a_reset_state", pk_a(), 12'd0);
        check("a_reset_tick", 12'(ia.step_tick), 12'd0);
        rst_a = 1'b1;
        drive_a(1, 0, 0, 0, 5'd0, 5'd0, 2'd1, "a_left_entry");
        drive_a(1, 0, 0, 0, 5'd1, 5'd0, 2'd1, "a_left_001");
        drive_a(1, 0, 0, 0, 5'd3, 5'd0, 2'd1, "a_left_011");
        drive_a(1, 0, 0, 0, 5'd7, 5'd0, 2'd1, "a_left_111");
        drive_a(1, 0, 0, 0, 5'd0, 5'd0, 2'd1, "a_left_wrap");
        drive_a(1, 0, 0, 0, 5'd1, 5'd0, 2'd1, "a_left_001b");
        drive_a(1, 0, 0, 0, 5'd3, 5'd0, 2'd1, "a_left_011b");
        @(negedge Clk);
        #2;
        rst_a = 1'b0;
        ia.LEFT = 1'b0;
        #1;
        check("a_midsweep_reset", pk_a(), 12'd0);
        check("a_midsweep_reset_tick", 12'(ia.step_tick), 12'd0);
        @(negedge Clk);
        rst_a = 1'b1;
        drive_a(0, 0, 0, 0, 5'd0, 5'd0, 2'd0, "a_post_reset_idle");
        drive_a(0, 1, 0, 0, 5'd0, 5'd0, 2'd2, "a_right_entry");
        drive_a(0, 1, 0, 0, 5'd0, 5'd1, 2'd2, "a_right_001");
        drive_a(0, 1, 0, 0, 5'd0, 5'd3, 2'd2, "a_right_011");
        drive_a(0, 1, 1, 0, 5'd7, 5'd7, 2'd3, "a_haz_entry");
        drive_a(0, 1, 1, 0, 5'd0, 5'd0, 2'd3, "a_haz_off");
        drive_a(0, 1, 1, 0, 5'd7, 5'd7, 2'd3, "a_haz_on");
        drive_a(0, 0, 0, 0, 5'd0, 5'd0, 2'd0, "a_idle");
        drive_a(0, 1, 0, 0, 5'd0, 5'd0, 2'd2, "a_right_entry2");
        drive_a(0, 1, 0, 0, 5'd0, 5'd1, 2'd2, "a_right_001b");
        drive_a(0, 1, 0, 0, 5'd0, 5'd3, 2'd2, "a_right_011b");
        drive_a(1, 1, 0, 0, 5'd7, 5'd7, 2'd3, "a_lr_entry");
        drive_a(1, 1, 0, 0, 5'd0, 5'd0, 2'd3, "a_lr_off");
        drive_a(1, 1, 0, 0, 5'd7, 5'd7, 2'd3, "a_lr_on");
        drive_a(1, 0, 0, 0, 5'd0, 5'd0, 2'd1, "a_haz_to_left");
        drive_a(1, 0, 0, 0, 5'd1, 5'd0, 2'd1, "a_left_001c");
        drive_a(1, 0, 0, 0, 5'd3, 5'd0, 2'd1, "a_left_011c");
        drive_a(1, 0, 0, 0, 5'd7, 5'd0, 2'd1, "a_left_111c");
        drive_a(0, 0, 0, 0, 5'd0, 5'd0, 2'd0, "a_release_left");
        drive_a(0, 0, 0, 0, 5'd0, 5'd0, 2'd0, "a_idle_hold");
        drive_a(1, 0, 1, 0, 5'd7, 5'd7, 2'd3, "a_haz_over_left");
        drive_a(0, 0, 0, 0, 5'd0, 5'd0, 2'd0, "a_idle2");
`ifdef TAILLIGHT_BRAKE_EN
        drive_a(0, 0, 0, 1, 5'd7, 5'd7, 2'd0, "a_brake_idle");
        drive_a(0, 0, 0, 0, 5'd0, 5'd0, 2'd0, "a_brake_release");
        drive_a(1, 0, 0, 0, 5'd0, 5'd0, 2'd1, "a_bl_entry");
        drive_a(1, 0, 0, 1, 5'd1, 5'd7, 2'd1, "a_brake_left_001");
        drive_a(1, 0, 0, 1, 5'd3, 5'd7, 2'd1, "a_brake_left_011");
        drive_a(1, 0, 0, 0, 5'd7, 5'd0, 2'd1, "a_brake_left_off");
        drive_a(0, 0, 1, 1, 5'd7, 5'd7, 2'd3, "a_brake_haz_on");
        drive_a(0, 0, 1, 1, 5'd0, 5'd0, 2'd3, "a_brake_haz_off");
        drive_a(0, 0, 1, 1, 5'd7, 5'd7, 2'd3, "a_brake_haz_on2");
        drive_a(0, 1, 0, 1, 5'd7, 5'd0, 2'd2, "a_brake_right_entry");
        drive_a(0, 1, 0, 1, 5'd7, 5'd1, 2'd2, "a_brake_right_001");
        drive_a(0, 0, 0, 0, 5'd0, 5'd0, 2'd0, "a_brake_done");
`endif
    endtask

    task automatic seq_b();
        ib.LEFT = 1'b0;
        ib.RIGHT = 1'b0;
        ib.HAZ = 1'b0;
        repeat (3) @(negedge Clk);
        check("b_reset_state", pk_b(), 12'd0);
        rst_b = 1'b1;
        drive_b(0, 1, 0, 5'd0, 5'd0, 2'd2, "b_right_entry");
        drive_b(0, 1, 0, 5'd0, 5'd1, 2'd2, "b_right_1");
        drive_b(0, 1, 0, 5'd0, 5'd3, 2'd2, "b_right_2");
        // LEFT pulses high for two clocks strictly between tick edges
        ib.RIGHT = 1'b1;
        qb.push_back('{5'd0, 5'd7, 2'd2, "b_pulse_ignored"});
        @(negedge Clk);
        ib.LEFT = 1'b1;
        repeat (2) @(negedge Clk);
        ib.LEFT = 1'b0;
        @(negedge Clk);
        drive_b(0, 1, 0, 5'd0, 5'd15, 2'd2, "b_right_4");
        drive_b(0, 1, 0, 5'd0, 5'd31, 2'd2, "b_right_5");
        drive_b(0, 1, 0, 5'd0, 5'd0, 2'd2, "b_right_wrap");
        drive_b(1, 0, 0, 5'd0, 5'd0, 2'd1, "b_left_entry");
        drive_b(1, 0, 0, 5'd1, 5'd0, 2'd1, "b_left_1");
        drive_b(1, 0, 0, 5'd3, 5'd0, 2'd1, "b_left_2");
        drive_b(1, 0, 0, 5'd7, 5'd0, 2'd1, "b_left_3");
        drive_b(1, 0, 0, 5'd15, 5'd0, 2'd1, "b_left_4");
        drive_b(1, 0, 0, 5'd31, 5'd0, 2'd1, "b_left_5");
        drive_b(1, 0, 0, 5'd0, 5'd0, 2'd1, "b_left_wrap");
        drive_b(0, 0, 0, 5'd0, 5'd0, 2'd0, "b_idle");
    endtask

    initial begin
        fork
            seq_a();
            seq_b();
        join
        repeat (4) @(negedge Clk);
        check("a_queue_drained", 12'(qa.size()), 12'd0);
        check("b_queue_drained", 12'(qb.size()), 12'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
